md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with architectural HI/LO registers, run beside the ALU in the
//   execute stage of the next-generation datapath. Executes MIPS mult/multu/div/divu and
//   mthi/mtlo; busy latency per operation class is set by parameter. The pipeline controller
//   stalls mfhi/mflo and further MD ops while busy=1.
// PARAMETERS
//   WIDTH       32  operand and HI/LO width in bits; even, >=8
//   MUL_CYCLES  5   busy cycles for mult/multu; >=1
//   DIV_CYCLES  10  busy cycles for div/divu; >=1
// PORTS
//   clk     in   1      single clock, all state updates on posedge
//   reset   in   1      asynchronous, active-high; clears all state immediately
//   start   in   1      one-cycle request strobe, sampled at posedge
//   md_op   in   3      000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; others none
//   a       in   WIDTH  rs operand (dividend / multiplicand / mthi, mtlo source)
//   b       in   WIDTH  rt operand (divisor / multiplier)
//   busy    out  1      high while an operation is in flight
//   hi      out  WIDTH  HI register (registered)
//   lo      out  WIDTH  LO register (registered)
// BEHAVIOUR
//   Reset: busy=0, hi=0, lo=0, cycle counter=0, latched op cleared; asserting reset mid-operation
//     aborts it, and no result is ever written.
//   Accept: posedge with start=1, busy=0, md_op in {001..100}: latch a, b, md_op; load the counter
//     with N (MUL_CYCLES or DIV_CYCLES); busy=1 from that edge.
//   Countdown: the counter decrements once per posedge while busy. busy stays high for exactly N
//     cycles. At the Nth edge after accept: busy=0 and hi/lo take the result on that same edge.
//     A new start is accepted on the edge where busy is already 0 (no overlap; back-to-back ops
//     are separated by N cycles).
//   start while busy=1: ignored entirely (op, operands, mthi/mtlo). The in-flight op is unaffected.
//   mthi/mtlo (start=1, busy=0): hi<=a (or lo<=a) on that edge; busy stays 0; the other register
//     is unchanged.
//   md_op none/undefined with start=1: no effect.
//   mult: signed WIDTH x WIDTH -> 2*WIDTH product; hi=upper half, lo=lower half.
//     multu: same, operands unsigned.
//   div: signed; lo=quotient truncated toward zero; hi=remainder, with the sign of the dividend.
//     divu: unsigned quotient and remainder.
//   Divide by zero (b=0, div or divu): the op runs the full DIV_CYCLES with busy; hi and lo are
//     left unchanged at completion.
//   Signed overflow (div, a=most negative, b=-1): lo=a (most negative value), hi=0.
//   The result is computed from the operands latched at accept; a/b changes during busy have no
//     effect. The datapath may be iterative or combinational plus a delay counter, provided the
//     visible timing above holds.
//   hi/lo change only on: completion edge, mthi/mtlo edge, reset.
// TESTING
//   1 mult a=0xFFFFFFFE(-2) b=0x00000003, MUL_CYCLES=5 -> busy high 5 cycles; then hi=0xFFFFFFFF,
//     lo=0xFFFFFFFA.
//   2 multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
//   3 div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1) after 10 busy cycles.
//     divu with the same operands -> lo=0x7FFFFFFC, hi=1.
//   4 mthi a=0x1234 then mtlo a=0x5678 -> hi=0x1234, lo=0x5678, busy never rises.
//     div a=5 b=0 -> busy 10 cycles, hi/lo still 0x1234/0x5678.
//   5 div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//     start mult during its busy window -> ignored, no extra busy cycles.
//   6 Reset pulse mid-div (cycle 4 of 10) -> busy=0, hi=lo=0 immediately (asynchronous).
//     A new mult accepted on the first edge after release completes normally.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Results are formed combinationally from operands latched at accept; a down-counter
// loaded with the operation latency holds busy high until the terminal count, where
// HI/LO are written (except divide-by-zero, which leaves them untouched).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | ready; start accepts mult/div ops or performs mthi/mtlo
//   S_BUSY  | op in flight; counter running down, new starts ignored
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_we;

    // Result datapath: product or magnitude-based division from the latched operands.
    always_comb begin
        prod     = '0;
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        dividend = a_q;
        divisor  = b_q;
        q_mag    = '0;
        r_mag    = '0;
        res_hi   = hi;
        res_lo   = lo;
        res_we   = 1'b0;

        case (op_q)
            OP_MULT: begin
                prod   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
                res_we = 1'b1;
            end
            OP_MULTU: begin
                prod   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
                res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                if (op_q == OP_DIV) begin
                    a_neg = a_q[WIDTH-1];
                    b_neg = b_q[WIDTH-1];
                end
                // The most negative dividend negates to itself, which read unsigned is
                // exactly its magnitude, so the overflow case falls out naturally.
                dividend = a_neg ? (~a_q + 1'b1) : a_q;
                divisor  = b_neg ? (~b_q + 1'b1) : b_q;
                if (divisor != '0) begin
                    q_mag  = dividend / divisor;
                    r_mag  = dividend % divisor;
                    res_lo = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
                    res_hi = a_neg ? (~r_mag + 1'b1) : r_mag;
                    res_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control FSM: accept/move in idle, count down while busy, write HI/LO at terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                op_q  <= md_op;
                                a_q   <= a;
                                b_q   <= b;
                                cnt   <= CNT_W'(MUL_CYCLES);
                                busy  <= 1'b1;
                                state <= S_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= md_op;
                                a_q   <= a;
                                b_q   <= b;
                                cnt   <= CNT_W'(DIV_CYCLES);
                                busy  <= 1'b1;
                                state <= S_BUSY;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                        op_q  <= OP_NONE;
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. The driver predicts each mult/div result
// with 64-bit integer arithmetic and queues it; a monitor pops on every busy fall and
// compares HI/LO and the observed busy length.
module tb_md_unit;

    localparam int W    = 32;
    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    md_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           n;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    md_unit #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural operands.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] ai,
                                   input logic [W-1:0] bi, input string nm);
        exp_t         e;
        longint       sa;
        longint       sbv;
        longint       ua;
        longint       ub;
        logic [63:0]  p;
        logic [63:0]  qv;
        logic [63:0]  rv;
        sa  = longint'($signed(ai));
        sbv = longint'($signed(bi));
        ua  = longint'({32'h0, ai});
        ub  = longint'({32'h0, bi});
        e.hi = exp_hi;
        e.lo = exp_lo;
        e.name = nm;
        e.n = (op == 3'd1 || op == 3'd2) ? MULN : DIVN;
        case (op)
            3'd1: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd2: begin p = ua * ub;  e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd3: if (bi != 0) begin
                qv = sa / sbv; rv = sa % sbv; e.hi = rv[31:0]; e.lo = qv[31:0];
            end
            3'd4: if (bi != 0) begin
                qv = ua / ub;  rv = ua % ub;  e.hi = rv[31:0]; e.lo = qv[31:0];
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy stuck at %b after %0d cycles", busy, g);
        end
    endtask

    // Issue one request while idle; the model is advanced at issue time.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] ai,
                         input logic [W-1:0] bi, input string nm);
        exp_t e;
        wait_idle();
        start = 1'b1;
        md_op = op;
        a     = ai;
        b     = bi;
        if (op >= 3'd1 && op <= 3'd4) begin
            e = model(op, ai, bi, nm);
            sb_q.push_back(e);
            exp_hi = e.hi;
            exp_lo = e.lo;
        end else if (op == 3'd5) begin
            exp_hi = ai;
        end else if (op == 3'd6) begin
            exp_lo = ai;
        end
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (!(op >= 3'd1 && op <= 3'd4)) begin
            check({nm, " busy"}, {31'h0, busy}, 0);
            check({nm, " hi"}, hi, exp_hi);
            check({nm, " lo"}, lo, exp_lo);
        end
    endtask

    // Drive a request for one cycle without waiting for idle (used only while busy).
    task automatic poke(input logic [2:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi);
        start = 1'b1;
        md_op = op;
        a     = ai;
        b     = bi;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every busy fall is a completion; compare against the oldest prediction.
    int  bcnt      = 0;
    bit  prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_busy = 1'b0;
            bcnt      = 0;
        end else begin
            if (busy) begin
                bcnt++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: busy fell after %0d cycles, none queued", bcnt);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, " hi"}, hi, e.hi);
                    check({e.name, " lo"}, lo, e.lo);
                    check({e.name, " busy_cycles"}, 32'(bcnt), 32'(e.n));
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        exp_t e;
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = 3'd0;
        a      = '0;
        b      = '0;
        exp_hi = '0;
        exp_lo = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'h0, busy}, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        reset = 1'b0;

        do_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg2x3");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
        do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, "divu_m7_2");
        do_op(3'd5, 32'h0000_1234, 32'h0, "mthi");
        do_op(3'd6, 32'h0000_5678, 32'h0, "mtlo");
        do_op(3'd3, 32'h0000_0005, 32'h0, "div_by_zero");
        do_op(3'd4, 32'h0000_0009, 32'h0, "divu_by_zero");
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        do_op(3'd7, 32'hAAAA_AAAA, 32'h0, "op_undef");
        do_op(3'd0, 32'hBBBB_BBBB, 32'h0, "op_none");

        // Requests during the busy window must vanish without a trace.
        do_op(3'd1, 32'h0000_0007, 32'hFFFF_FFFD, "mult_busy_ignore");
        poke(3'd1, 32'h1111_1111, 32'h2222_2222);
        poke(3'd5, 32'hDEAD_BEEF, 32'h0);
        poke(3'd6, 32'hCAFE_F00D, 32'h0);

        // Asynchronous reset in the middle of a divide.
        do_op(3'd3, 32'h0000_0064, 32'h0000_0007, "div_aborted");
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort busy", {31'h0, busy}, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        void'(sb_q.pop_back());
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd1;
        a     = 32'h0001_0000;
        b     = 32'h0003_0000;
        e = model(3'd1, a, b, "mult_after_reset");
        sb_q.push_back(e);
        exp_hi = e.hi;
        exp_lo = e.lo;
        #1 reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("post_reset accept busy", {31'h0, busy}, 1);

        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), $sformatf("rnd%0d", i));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
